// File: rtl/instr_mem_fetch.sv
// Instruction memory with a valid/ready fetch port, a byte-strobed load port and a self-clearing init sequencer.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instr_mem_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                rsp_fault,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_err,
    output logic                      init_done
`ifdef IMEM_PARITY_EN
    ,
    input  logic                      par_flip
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(NB);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFFS) - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(MEM_DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        init_idx;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   rd_word, wr_word;
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic                    rd_mis, rd_oor, wr_oor, rd_par_err;
    logic [DATA_WIDTH-1:0]   rd_data, wr_old, wr_merged;
    logic                    wr_fire, wr_do, req_fire;

    // Range checks use the full shifted address so high bits never alias onto a valid word.
    assign rd_word = req_addr >> OFFS;
    assign wr_word = wr_addr >> OFFS;
    assign rd_idx  = rd_word[IDX_W-1:0];
    assign wr_idx  = wr_word[IDX_W-1:0];
    assign rd_oor  = {1'b0, rd_word} >= DEPTH_EXT;
    assign wr_oor  = {1'b0, wr_word} >= DEPTH_EXT;
    assign rd_mis  = |(req_addr & ALIGN_MASK);
    assign rd_data = rd_oor ? '0 : mem[rd_idx];
    assign wr_old  = wr_oor ? '0 : mem[wr_idx];

    assign wr_fire   = (state == S_RUN) && en && wr_en;
    assign wr_do     = wr_fire && !wr_oor;
    assign req_ready = (state == S_RUN) && en && !wr_en && (!rsp_valid || rsp_ready);
    assign req_fire  = req_valid && req_ready;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    // NOTE: storage arrays have no reset; the init sequencer fills them after every reset instead.
    always_ff @(posedge clk) begin
        if (state == S_INIT) mem[init_idx] <= FILL_VALUE;
        else if (wr_do)      mem[wr_idx]   <= wr_merged;
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (state == S_INIT) par_mem[init_idx] <= ^FILL_VALUE;
        else if (wr_do)      par_mem[wr_idx]   <= (^wr_merged) ^ par_flip;
    end

    assign rd_par_err = !rd_oor && ((^rd_data) ^ par_mem[rd_idx]);
`else
    assign rd_par_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            init_idx  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_fault <= 2'b00;
            wr_err    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            wr_err <= wr_fire && wr_oor;

            case (state)
                S_INIT: begin
                    if (init_idx == LAST_IDX) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_idx <= init_idx + IDX_W'(1);
                    end
                end
                S_RUN: ;
                default: state <= S_INIT;
            endcase

            if (req_fire) begin
                rsp_valid <= 1'b1;
                rsp_fault <= {rd_oor, rd_mis | rd_par_err};
                rsp_data  <= (rd_oor || rd_mis || rd_par_err) ? '0 : rd_data;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch (depth 16): directed scenarios plus randomized
// load/fetch traffic checked against a word-array reference model.
module tb_instr_mem_fetch;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, en, req_valid, req_ready, rsp_valid, rsp_ready;
    logic          wr_en, wr_err, init_done;
    logic [AW-1:0] req_addr, wr_addr;
    logic [DW-1:0] rsp_data, wr_data;
    logic [1:0]    rsp_fault;
    logic [3:0]    wr_strb;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [DEPTH];

    instr_mem_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .FILL_VALUE(32'hFFFF_FFFF)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data),
        .wr_err(wr_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a / 4) < DEPTH;
    endfunction

    function automatic logic [1:0] exp_fault(input logic [AW-1:0] a);
        return {!in_range(a), (a % 4) != 0};
    endfunction

    function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
        if (exp_fault(a) != 2'b00) return 32'h0;
        return model[int'(a / 4)];
    endfunction

    task automatic model_fill();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'hFFFF_FFFF;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        en = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        step();
        wr_en = 1'b0;
        check("wr_err", wr_err, !in_range(a));
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[int'(a / 4)][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic do_fetch(input logic [AW-1:0] a);
        en = 1'b1; req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        #1;
        check("fetch_req_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        check("fetch_rsp_valid", rsp_valid, 1'b1);
        check("fetch_rsp_data", rsp_data, exp_data(a));
        check("fetch_rsp_fault", rsp_fault, exp_fault(a));
    endtask

    // Releases reset and checks init takes exactly DEPTH cycles, regardless of en and port traffic.
    task automatic run_init();
        rst = 1'b0;
        model_fill();
        en = 1'b0; req_valid = 1'b1; req_addr = '0;
        repeat (DEPTH - 1) step();
        check("init_not_done", init_done, 1'b0);
        check("init_no_rsp", rsp_valid, 1'b0);
        step();
        check("init_done", init_done, 1'b1);
        req_valid = 1'b0; en = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [3:0]    s;

        rst = 1'b1; en = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_strb = '0; wr_data = '0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);
        check("rst_rsp_fault", rsp_fault, 2'b00);
        repeat (3) step();
        run_init();
        for (int i = 0; i < DEPTH; i++) do_fetch(AW'(i * 4));

        // Streaming: one response per cycle, in request order.
        for (int i = 0; i < 8; i++) do_write(AW'(i * 4), 32'h1111_0000 + 32'(i), 4'hF);
        req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = AW'(i * 4);
            #1;
            check("stream_req_ready", req_ready, 1'b1);
            @(posedge clk); #1;
            check("stream_rsp_valid", rsp_valid, 1'b1);
            check("stream_rsp_data", rsp_data, 32'h1111_0000 + 32'(i));
        end
        req_valid = 1'b0;
        step();
        check("stream_drain", rsp_valid, 1'b0);

        // Backpressure: held response stays stable, no new accept until consumed.
        req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0; req_addr = 32'hC;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_data", rsp_data, model[2]);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        check("bp_next_data", rsp_data, model[3]);
        req_valid = 1'b0;
        step();

        // Byte strobes.
        do_write(32'hC, 32'hAABB_CCDD, 4'hF);
        do_write(32'hC, 32'h1122_3344, 4'b0101);
        do_fetch(32'hC);
        check("strb_merge", rsp_data, 32'hAA22_CC44);
        do_write(32'hC, 32'h0, 4'b0000);
        do_fetch(32'hC);

        // Faults and dropped out-of-range writes.
        do_fetch(32'h2);
        check("fault_mis", rsp_fault, 2'b01);
        do_fetch(32'h40);
        check("fault_oor", rsp_fault, 2'b10);
        do_fetch(32'h41);
        check("fault_both", rsp_fault, 2'b11);
        do_fetch(32'h1000_0004);
        do_write(32'h40, 32'h1234_5678, 4'hF);
        step();
        check("wr_err_pulse_end", wr_err, 1'b0);
        do_fetch(32'h0);

        // Load port beats fetch in the same cycle; fetch then sees the new word.
        en = 1'b1; wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hCAFE_BABE; wr_strb = 4'hF;
        req_valid = 1'b1; req_addr = 32'h14; rsp_ready = 1'b1;
        #1;
        check("prio_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[5] = 32'hCAFE_BABE;
        check("prio_no_rsp", rsp_valid, 1'b0);
        #1;
        check("prio_ready_after", req_ready, 1'b1);
        @(posedge clk); #1;
        check("prio_new_data", rsp_data, 32'hCAFE_BABE);
        req_valid = 1'b0;

        // en low: no accept, no write.
        en = 1'b0; wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'h0; req_valid = 1'b1;
        #1;
        check("en_low_ready", req_ready, 1'b0);
        step();
        check("en_low_no_rsp", rsp_valid, 1'b0);
        check("en_low_wr_err", wr_err, 1'b0);
        wr_en = 1'b0; req_valid = 1'b0;
        do_fetch(32'h14);

        // en low holds a pending response, which can still be consumed.
        req_valid = 1'b1; req_addr = 32'h18; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0; rsp_ready = 1'b0; en = 1'b0;
        repeat (3) step();
        check("en_hold_valid", rsp_valid, 1'b1);
        check("en_hold_data", rsp_data, model[6]);
        rsp_ready = 1'b1;
        step();
        check("en_consume", rsp_valid, 1'b0);
        en = 1'b1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = AW'($urandom_range(0, 19) * 4);
                s = 4'($urandom_range(0, 15));
                do_write(a, $urandom, s);
            end else begin
                if ($urandom_range(0, 9) == 0) a = $urandom;
                else a = AW'($urandom_range(0, 32'h4F));
                do_fetch(a);
            end
        end

        // Asynchronous reset with a response pending, then full refill.
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        check("pre_rst_valid", rsp_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", rsp_valid, 1'b0);
        check("async_rst_data", rsp_data, 32'h0);
        check("async_rst_init_done", init_done, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        run_init();
        for (int i = 0; i < DEPTH; i++) do_fetch(AW'(i * 4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
